// File: rtl/d16_pkg.sv
// Shared definitions for the d16 Wishbone bus fabric: arbiter state encoding
// and the default forced-release limit.
package d16_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_t;

    localparam int D16_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/d16_wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter: round-robin on ties, no split
// transfers, and forced release of a master whose slave never acknowledges.
module d16_wb_arbiter
    import d16_pkg::*;
#(
    parameter int TIMEOUT = D16_TIMEOUT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_m0_cyc,
    input  logic        i_m0_we,
    input  logic [15:0] i_m0_addr,
    input  logic [15:0] i_m0_dat,
    output logic [15:0] o_m0_dat,
    output logic        o_m0_ack,
    output logic        o_m0_stall,
    output logic        o_m0_err,
    input  logic        i_m1_cyc,
    input  logic        i_m1_we,
    input  logic [15:0] i_m1_addr,
    input  logic [15:0] i_m1_dat,
    output logic [15:0] o_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_stall,
    output logic        o_m1_err,
    output logic        o_s_cyc,
    output logic        o_s_we,
    output logic [15:0] o_s_addr,
    output logic [15:0] o_s_dat,
    input  logic [15:0] i_s_dat,
    input  logic        i_s_ack
);

    // The counter holds completed wait cycles, so the limit fires one count early.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    arb_state_t  state;
    logic        last_grant;
    logic [15:0] wait_cnt;

    logic g0;
    logic g1;
    logic grant_cyc;
    logic timeout;

    assign g0        = (state == GRANT0);
    assign g1        = (state == GRANT1);
    assign grant_cyc = (g0 & i_m0_cyc) | (g1 & i_m1_cyc);
    assign timeout   = grant_cyc & ~i_s_ack & (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= 16'h0000;
                    if (i_m0_cyc && (!i_m1_cyc || last_grant))
                        state <= GRANT0;
                    else if (i_m1_cyc)
                        state <= GRANT1;
                end
                GRANT0: begin
                    if (!i_m0_cyc || timeout) begin
                        last_grant <= 1'b0;
                        wait_cnt   <= 16'h0000;
                        state      <= i_m1_cyc ? GRANT1 : IDLE;
                    end else if (i_s_ack) begin
                        wait_cnt <= 16'h0000;
                    end else begin
                        wait_cnt <= wait_cnt + 16'h0001;
                    end
                end
                GRANT1: begin
                    if (!i_m1_cyc || timeout) begin
                        last_grant <= 1'b1;
                        wait_cnt   <= 16'h0000;
                        state      <= i_m0_cyc ? GRANT0 : IDLE;
                    end else if (i_s_ack) begin
                        wait_cnt <= 16'h0000;
                    end else begin
                        wait_cnt <= wait_cnt + 16'h0001;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= 16'h0000;
                end
            endcase
        end
    end

    // Slave side follows the granted master combinationally; IDLE drives zeros.
    always_comb begin
        o_s_cyc  = 1'b0;
        o_s_we   = 1'b0;
        o_s_addr = 16'h0000;
        o_s_dat  = 16'h0000;
        if (g0) begin
            o_s_cyc  = i_m0_cyc;
            o_s_we   = i_m0_we;
            o_s_addr = i_m0_addr;
            o_s_dat  = i_m0_dat;
        end else if (g1) begin
            o_s_cyc  = i_m1_cyc;
            o_s_we   = i_m1_we;
            o_s_addr = i_m1_addr;
            o_s_dat  = i_m1_dat;
        end
    end

    assign o_m0_dat   = i_s_dat;
    assign o_m1_dat   = i_s_dat;
    assign o_m0_ack   = g0 & i_s_ack;
    assign o_m1_ack   = g1 & i_s_ack;
    assign o_m0_err   = g0 & timeout;
    assign o_m1_err   = g1 & timeout;
    assign o_m0_stall = i_m0_cyc & ~g0;
    assign o_m1_stall = i_m1_cyc & ~g1;

endmodule

// File: tb/tb_d16_wb_arbiter.sv
// Directed bench for d16_wb_arbiter with a short forced-release limit.
module tb_d16_wb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_m0_cyc, i_m0_we;
    logic [15:0] i_m0_addr, i_m0_dat;
    logic [15:0] o_m0_dat;
    logic        o_m0_ack, o_m0_stall, o_m0_err;
    logic        i_m1_cyc, i_m1_we;
    logic [15:0] i_m1_addr, i_m1_dat;
    logic [15:0] o_m1_dat;
    logic        o_m1_ack, o_m1_stall, o_m1_err;
    logic        o_s_cyc, o_s_we;
    logic [15:0] o_s_addr, o_s_dat;
    logic [15:0] i_s_dat;
    logic        i_s_ack;

    int errors = 0;
    int checks = 0;

    d16_wb_arbiter #(.TIMEOUT(4)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_m0_cyc   (i_m0_cyc),
        .i_m0_we    (i_m0_we),
        .i_m0_addr  (i_m0_addr),
        .i_m0_dat   (i_m0_dat),
        .o_m0_dat   (o_m0_dat),
        .o_m0_ack   (o_m0_ack),
        .o_m0_stall (o_m0_stall),
        .o_m0_err   (o_m0_err),
        .i_m1_cyc   (i_m1_cyc),
        .i_m1_we    (i_m1_we),
        .i_m1_addr  (i_m1_addr),
        .i_m1_dat   (i_m1_dat),
        .o_m1_dat   (o_m1_dat),
        .o_m1_ack   (o_m1_ack),
        .o_m1_stall (o_m1_stall),
        .o_m1_err   (o_m1_err),
        .o_s_cyc    (o_s_cyc),
        .o_s_we     (o_s_we),
        .o_s_addr   (o_s_addr),
        .o_s_dat    (o_s_dat),
        .i_s_dat    (i_s_dat),
        .i_s_ack    (i_s_ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_m0_cyc = 1'b1; i_m0_we = 1'b0; i_m0_addr = 16'h1000; i_m0_dat = 16'h0A0A;
        i_m1_cyc = 1'b0; i_m1_we = 1'b1; i_m1_addr = 16'h2000; i_m1_dat = 16'h0B0B;
        i_s_dat = 16'h5A5A; i_s_ack = 1'b1;
        #3;
        chk("rst_s_cyc",    {15'd0, o_s_cyc},    16'd0);
        chk("rst_s_addr",   o_s_addr,            16'h0000);
        chk("rst_m0_ack",   {15'd0, o_m0_ack},   16'd0);
        chk("rst_m0_stall", {15'd0, o_m0_stall}, 16'd1);
        chk("rst_m1_stall", {15'd0, o_m1_stall}, 16'd0);
        chk("rst_dat_pass", o_m1_dat,            16'h5A5A);
        tick();
        tick();
        chk("rst_hold_s_cyc", {15'd0, o_s_cyc}, 16'd0);
        i_m0_cyc = 1'b0; i_s_ack = 1'b0;
        i_reset_n = 1'b1;
        tick();

        // Single read from m0, slave acks in cycle 3.
        i_m0_cyc = 1'b1; i_m0_addr = 16'h1234; i_m0_we = 1'b0;
        #1;
        chk("c0_s_cyc",    {15'd0, o_s_cyc},    16'd0);
        chk("c0_m0_stall", {15'd0, o_m0_stall}, 16'd1);
        tick();
        chk("c1_s_cyc",    {15'd0, o_s_cyc},    16'd1);
        chk("c1_s_addr",   o_s_addr,            16'h1234);
        chk("c1_s_we",     {15'd0, o_s_we},     16'd0);
        chk("c1_m0_stall", {15'd0, o_m0_stall}, 16'd0);
        chk("c1_m0_ack",   {15'd0, o_m0_ack},   16'd0);
        tick();
        chk("c2_m0_ack", {15'd0, o_m0_ack}, 16'd0);
        tick();
        i_s_ack = 1'b1; i_s_dat = 16'hBEEF; i_m0_cyc = 1'b0;
        #1;
        chk("c3_m0_ack", {15'd0, o_m0_ack}, 16'd1);
        chk("c3_m0_dat", o_m0_dat,          16'hBEEF);
        chk("c3_m1_ack", {15'd0, o_m1_ack}, 16'd0);
        chk("c3_m0_err", {15'd0, o_m0_err}, 16'd0);
        tick();
        chk("c4_idle_ack_drop", {15'd0, o_m0_ack}, 16'd0);
        chk("c4_s_cyc",         {15'd0, o_s_cyc},  16'd0);
        i_s_ack = 1'b0;

        // Reset pulse restores m0 priority on the first tie.
        #1 i_reset_n = 1'b0;
        #3 i_reset_n = 1'b1;
        tick();
        i_m0_cyc = 1'b1; i_m0_addr = 16'h1000; i_m1_cyc = 1'b1; i_m1_addr = 16'h2000;
        tick();
        chk("tie_addr",     o_s_addr,            16'h1000);
        chk("tie_m1_stall", {15'd0, o_m1_stall}, 16'd1);
        chk("tie_m0_stall", {15'd0, o_m0_stall}, 16'd0);
        tick();
        chk("tie_hold_addr", o_s_addr,            16'h1000);
        i_m0_cyc = 1'b0; i_s_ack = 1'b1;
        #1;
        chk("tie_m0_ack",    {15'd0, o_m0_ack},   16'd1);
        chk("tie_m1_stall2", {15'd0, o_m1_stall}, 16'd1);
        tick();
        i_s_ack = 1'b0;
        #1;
        chk("handoff_s_cyc",  {15'd0, o_s_cyc},    16'd1);
        chk("handoff_addr",   o_s_addr,            16'h2000);
        chk("handoff_s_we",   {15'd0, o_s_we},     16'd1);
        chk("handoff_s_dat",  o_s_dat,             16'h0B0B);
        chk("handoff_stall",  {15'd0, o_m1_stall}, 16'd0);
        i_m1_cyc = 1'b0; i_s_ack = 1'b1;
        #1;
        chk("m1_ack", {15'd0, o_m1_ack}, 16'd1);
        chk("m1_ack_not_m0", {15'd0, o_m0_ack}, 16'd0);
        tick();
        i_s_ack = 1'b0;
        #1;
        chk("after_m1_idle", {15'd0, o_s_cyc}, 16'd0);

        // Back-to-back round robin, one-cycle transfers.
        i_m0_cyc = 1'b1; i_m1_cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i % 2 == 0) begin
                i_m0_cyc = 1'b0; i_m1_cyc = 1'b1;
            end else begin
                i_m1_cyc = 1'b0; i_m0_cyc = 1'b1;
            end
            i_s_ack = 1'b1;
            #1;
            chk("rr_addr", o_s_addr, (i % 2 == 0) ? 16'h1000 : 16'h2000);
            chk("rr_ack",  {15'd0, (i % 2 == 0) ? o_m0_ack : o_m1_ack}, 16'd1);
        end
        i_m0_cyc = 1'b0; i_m1_cyc = 1'b0; i_s_ack = 1'b0;
        tick();
        tick();
        chk("rr_end_s_cyc", {15'd0, o_s_cyc}, 16'd0);

        // Slave never answers m1: forced release on the 4th wait cycle.
        i_m1_cyc = 1'b1;
        tick();
        chk("to_w1_err",   {15'd0, o_m1_err}, 16'd0);
        chk("to_w1_s_cyc", {15'd0, o_s_cyc},  16'd1);
        tick();
        chk("to_w2_err", {15'd0, o_m1_err}, 16'd0);
        tick();
        chk("to_w3_err", {15'd0, o_m1_err}, 16'd0);
        tick();
        chk("to_w4_err", {15'd0, o_m1_err}, 16'd1);
        chk("to_w4_ack", {15'd0, o_m1_ack}, 16'd0);
        chk("to_w4_m0_err", {15'd0, o_m0_err}, 16'd0);
        tick();
        chk("to_rel_s_cyc", {15'd0, o_s_cyc},    16'd0);
        chk("to_rel_err",   {15'd0, o_m1_err},   16'd0);
        chk("to_rel_stall", {15'd0, o_m1_stall}, 16'd1);
        i_m1_cyc = 1'b0;
        tick();

        // Ack arriving on the exact timeout cycle wins.
        i_m0_cyc = 1'b1;
        tick();
        tick();
        tick();
        chk("at_w3_err", {15'd0, o_m0_err}, 16'd0);
        tick();
        i_s_ack = 1'b1; i_m0_cyc = 1'b0;
        #1;
        chk("at_ack", {15'd0, o_m0_ack}, 16'd1);
        chk("at_err", {15'd0, o_m0_err}, 16'd0);
        tick();
        i_s_ack = 1'b0;

        // Tie now favours m1; then reset hits mid-GRANT1.
        i_m0_cyc = 1'b1; i_m1_cyc = 1'b1;
        tick();
        chk("rr_tie_m1_addr", o_s_addr, 16'h2000);
        i_s_ack = 1'b1;
        #1 i_reset_n = 1'b0;
        #1;
        chk("ar_s_cyc",    {15'd0, o_s_cyc},    16'd0);
        chk("ar_m1_ack",   {15'd0, o_m1_ack},   16'd0);
        chk("ar_m1_stall", {15'd0, o_m1_stall}, 16'd1);
        i_s_ack = 1'b0;
        tick();
        i_reset_n = 1'b1;
        tick();
        chk("ar_tie_m0_addr", o_s_addr, 16'h1000);
        chk("ar_tie_m1_stall", {15'd0, o_m1_stall}, 16'd1);

        i_m0_cyc = 1'b0; i_m1_cyc = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/d16_wb_arbiter.md
D16_WB_ARBITER -- requirements
Module: d16_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles a granted master may wait for i_s_ack before forced release; 1..65535.
REQ-002 i_clk  in  1  sole clock, all state on rising edge.
REQ-003 i_reset_n  in  1  asynchronous active-low reset.
REQ-004 i_m0_cyc, i_m0_we  in  1 each  master 0 (CPU) cycle request, write enable.
REQ-005 i_m0_addr, i_m0_dat  in  16 each  master 0 address, write data.
REQ-006 o_m0_dat  out  16  read data to master 0.
REQ-007 o_m0_ack, o_m0_stall, o_m0_err  out  1 each  ack, wait, timeout-error to master 0.
REQ-008 i_m1_cyc, i_m1_we, i_m1_addr, i_m1_dat, o_m1_dat, o_m1_ack, o_m1_stall, o_m1_err: same widths and meaning for master 1 (loader/DMA).
REQ-009 o_s_cyc, o_s_we  out  1 each  slave cycle, write enable.
REQ-010 o_s_addr, o_s_dat  out  16 each  slave address, write data.
REQ-011 i_s_dat  in  16  slave read data; i_s_ack  in  1  slave acknowledge.

Function
REQ-012 FSM states: IDLE, GRANT0, GRANT1; state registered.
REQ-013 IDLE: m0 only requesting -> GRANT0; m1 only -> GRANT1; both -> master not granted most recently (register last_grant); none -> IDLE.
REQ-014 Grant latency: exactly one cycle from request seen in IDLE to GRANTn.
REQ-015 In GRANTn: o_s_cyc/we/addr/dat combinationally equal master n inputs; in IDLE o_s_cyc=0, o_s_we=0, o_s_addr=0, o_s_dat=0.
REQ-016 o_m0_dat and o_m1_dat both equal i_s_dat at all times.
REQ-017 o_mN_ack = i_s_ack only in GRANTn, else 0; slave ack in IDLE is dropped.
REQ-018 o_mN_stall = i_mN_cyc and state != GRANTn.
REQ-019 GRANTn exit when i_mN_cyc=0: if other master has cyc=1 -> GRANT(other) directly next cycle, else IDLE; last_grant <= n.
REQ-020 Wait counter (16 bit): cleared on grant entry and on every i_s_ack; increments each GRANTn cycle with i_mN_cyc=1 and i_s_ack=0.
REQ-021 Counter reaching TIMEOUT: o_mN_err=1 for exactly that cycle, o_mN_ack=0 that cycle, next state per REQ-019 rules treating master n as released, last_grant <= n.
REQ-022 Ack and timeout in same cycle: ack wins, no err, counter cleared.
REQ-023 Master dropping cyc in same cycle as ack: ack still forwarded, release per REQ-019.
REQ-024 Grant never changes while granted master holds cyc and not timed out; no bus transfer is split.

Reset
REQ-025 Asynchronous on i_reset_n=0: state=IDLE, last_grant=1 (m0 wins first tie), counter=0.
REQ-026 During and after reset all outputs at IDLE values: o_s_cyc=0, all acks/errs 0, stalls follow REQ-018.
REQ-027 Reset asserted mid-transfer aborts immediately; no ack forwarded; arbitration restarts from IDLE after release.

Structure
REQ-028 Shared package d16_pkg holds state encoding (IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10) and default TIMEOUT constant.
REQ-029 Single module; no sub-modules; output mux is combinational from registered state.

Verification
REQ-030 Single request: m0 cyc at cycle 0, addr 16'h1234 read, slave acks cycle 3 with 16'hBEEF -> GRANT0 at cycle 1, o_m0_ack=1 and o_m0_dat=16'hBEEF at cycle 3, m1 ack never 1.
REQ-031 Tie after reset: both cyc at cycle 0 -> GRANT0; m1 stall=1 until m0 drops cyc, then GRANT1 next cycle with no IDLE gap.
REQ-032 Round-robin: both hold continuous back-to-back requests for 4 transfers -> grant order 0,1,0,1.
REQ-033 Timeout: TIMEOUT=4, m1 granted, slave never acks -> o_m1_err=1 on 4th wait cycle only, o_s_cyc=0 next cycle if m0 idle.
REQ-034 Ack-vs-timeout: i_s_ack on exact timeout cycle -> o_mN_ack=1, o_mN_err=0.
REQ-035 Async reset: assert i_reset_n=0 mid-GRANT1 between clock edges -> o_s_cyc=0 immediately, state IDLE, next tie goes to m0.
